cache_mem_arbiter: RTL and testbench

- Shares the single-port cache DFFRAM (sync read, 1-cycle latency, per-byte write enables) between two requesters: m0 (CPU cache controller) and m1 (management/debug loader).
- Sits between the SoC-side requesters and the `cache_mem` ports in the top level.
- Optionally zero-fills the whole RAM after reset, holding off all grants until the fill completes.
- Round-robin arbitration, one RAM command per cycle, read data routed back to the issuing requester.

---
 rtl/cache_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing the single-port cache RAM between m0 and m1, with optional zero-fill sweep after reset.
// Grants are combinational, read data returns one cycle later; define CACHE_ARB_LOCK_EN to add m0_lock/m1_lock grant holding.
module cache_mem_arbiter #(
    parameter int ADDR_W         = 14,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_sel,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_sel,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
`ifdef CACHE_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_wr,
    output logic              mem_we,
    output logic [3:0]        mem_we_sel,
    input  logic [31:0]       mem_data_rd,
    output logic              init_busy
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   clr_addr, clr_addr_nxt;
    logic              rr_last;
    logic              rd_pend;
    logic              rd_owner;
    logic [ADDR_W-1:0] addr_hold;
    logic              hold0, hold1;

`ifdef CACHE_ARB_LOCK_EN
    logic gnt_prev;

    // A lock only sticks to the port that actually won the previous cycle.
    assign hold0 = gnt_prev && !rr_last && m0_req && m0_lock;
    assign hold1 = gnt_prev &&  rr_last && m1_req && m1_lock;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gnt_prev <= 1'b0;
        end else begin
            gnt_prev <= m0_gnt || m1_gnt;
        end
    end
`else
    assign hold0 = 1'b0;
    assign hold1 = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        mem_addr     = addr_hold;
        mem_data_wr  = 32'h0;
        mem_we       = 1'b0;
        mem_we_sel   = 4'h0;
        if (!sys_rst) begin
            if (state == CLEAR) begin
                mem_addr     = clr_addr[ADDR_W-1:0];
                mem_we       = 1'b1;
                mem_we_sel   = 4'hF;
                clr_addr_nxt = clr_addr + 1'b1;
                if (clr_addr == CLR_LAST) begin
                    state_nxt = RUN;
                end
            end else begin
                if (hold0) begin
                    m0_gnt = 1'b1;
                end else if (hold1) begin
                    m1_gnt = 1'b1;
                end else if (m0_req && m1_req) begin
                    m0_gnt = rr_last;
                    m1_gnt = !rr_last;
                end else begin
                    m0_gnt = m0_req;
                    m1_gnt = m1_req;
                end

                if (m0_gnt) begin
                    mem_addr    = m0_addr;
                    mem_data_wr = m0_wdata;
                    mem_we      = m0_we;
                    mem_we_sel  = m0_we ? m0_sel : 4'h0;
                end else if (m1_gnt) begin
                    mem_addr    = m1_addr;
                    mem_data_wr = m1_wdata;
                    mem_we      = m1_we;
                    mem_we_sel  = m1_we ? m1_sel : 4'h0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr  <= '0;
            rr_last   <= 1'b1;
            rd_pend   <= 1'b0;
            rd_owner  <= 1'b0;
            addr_hold <= '0;
        end else begin
            state     <= state_nxt;
            clr_addr  <= clr_addr_nxt;
            addr_hold <= mem_addr;
            rd_pend   <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
            if (m0_gnt || m1_gnt) begin
                rr_last  <= m1_gnt;
                rd_owner <= m1_gnt;
            end
        end
    end

    assign init_busy = (state == CLEAR);
    assign m0_rvalid = rd_pend && !rd_owner;
    assign m1_rvalid = rd_pend &&  rd_owner;
    assign m0_rdata  = m0_rvalid ? mem_data_rd : 32'h0;
    assign m1_rdata  = m1_rvalid ? mem_data_rd : 32'h0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: small RAM model, directed scenarios and a randomized run checked against a reference model.
module tb_cache_mem_arbiter;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0]        m0_sel = 4'h0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [31:0]       m0_wdata = 32'h0;
    logic              m0_gnt, m0_rvalid;
    logic [31:0]       m0_rdata;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0]        m1_sel = 4'h0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [31:0]       m1_wdata = 32'h0;
    logic              m1_gnt, m1_rvalid;
    logic [31:0]       m1_rdata;
`ifdef CACHE_ARB_LOCK_EN
    logic              m0_lock = 1'b0, m1_lock = 1'b0;
`endif
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data_wr;
    logic              mem_we;
    logic [3:0]        mem_we_sel;
    logic [31:0]       mem_data_rd = 32'h0;
    logic              init_busy;

    logic [31:0] ram     [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          last_port = 1;
    logic        ev_vld = 1'b0;
    logic        ev_port = 1'b0;
    logic [31:0] ev_data = 32'h0;
    logic [1:0]  exp_rv;
    logic [31:0] exp_d0, exp_d1;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef CACHE_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .mem_addr(mem_addr), .mem_data_wr(mem_data_wr), .mem_we(mem_we), .mem_we_sel(mem_we_sel),
        .mem_data_rd(mem_data_rd), .init_busy(init_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Single-port RAM: synchronous read, per-byte writes.
    always @(posedge sys_clk) begin
        mem_data_rd <= ram[mem_addr];
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_we_sel[b]) ram[mem_addr][8*b +: 8] = mem_data_wr[8*b +: 8];
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic test_reset;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd7;
        m1_req = 1'b1; m1_we = 1'b1; m1_sel = 4'hF; m1_addr = 5'd2;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b, expected 00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we});
        end
        checks++;
        if (mem_we_sel !== 4'h0 || mem_addr !== 5'd0) begin
            errors++; $display("FAIL reset_mem_bus: got sel=%h addr=%h, expected 0/0", mem_we_sel, mem_addr);
        end
        checks++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h, expected 0/0", m0_rdata, m1_rdata);
        end
        checks++;
        if (init_busy !== 1'b1) begin
            errors++; $display("FAIL reset_init_busy: got %b, expected 1", init_busy);
        end
        m1_req = 1'b0; m1_we = 1'b0;
    endtask

    task automatic test_clear;
        int busy_cnt;
        int nonzero;
        busy_cnt = 0;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            @(negedge sys_clk);
            if (!init_busy) break;
            checks++;
            if (mem_we !== 1'b1 || mem_we_sel !== 4'hF || mem_data_wr !== 32'h0 ||
                mem_addr !== ADDR_W'(busy_cnt) || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
                errors++;
                $display("FAIL clear_cycle%0d: got we=%b sel=%h data=%h addr=%h gnt=%b%b, expected 1 F 0 %h 00",
                         busy_cnt, mem_we, mem_we_sel, mem_data_wr, mem_addr, m0_gnt, m1_gnt, ADDR_W'(busy_cnt));
            end
            busy_cnt++;
        end
        checks++;
        if (busy_cnt != DEPTH) begin
            errors++; $display("FAIL clear_length: got %0d busy cycles, expected %0d", busy_cnt, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = 32'h0;
        checks++;
        if (init_busy !== 1'b0 || m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_addr !== 5'd7 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL clear_first_grant: got busy=%b gnt=%b%b addr=%h we=%b, expected 0 10 07 0",
                     init_busy, m0_gnt, m1_gnt, mem_addr, mem_we);
        end
        last_port = 0;
        @(posedge sys_clk); #1 m0_req = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== exp_mem[7] || m1_rvalid !== 1'b0) begin
            errors++; $display("FAIL clear_read7: got rv=%b%b data=%h, expected 10 %h", m0_rvalid, m1_rvalid, m0_rdata, exp_mem[7]);
        end
        nonzero = 0;
        for (int a = 0; a < DEPTH; a++) if (ram[a] !== 32'h0) nonzero++;
        checks++;
        if (nonzero != 0) begin
            errors++; $display("FAIL clear_ram_zero: got %0d nonzero words, expected 0", nonzero);
        end
    endtask

    task automatic test_write_read;
        @(posedge sys_clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_sel = 4'b0011; m0_addr = 5'h10; m0_wdata = 32'h12345678;
        @(negedge sys_clk);
        checks++;
        if (m0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_we_sel !== 4'b0011 || mem_addr !== 5'h10 || mem_data_wr !== 32'h12345678) begin
            errors++;
            $display("FAIL wr_cmd: got gnt=%b we=%b sel=%h addr=%h data=%h, expected 1 1 3 10 12345678",
                     m0_gnt, mem_we, mem_we_sel, mem_addr, mem_data_wr);
        end
        exp_mem[16] = merge(exp_mem[16], 32'h12345678, 4'b0011);
        last_port = 0;
        @(posedge sys_clk); #1 m0_we = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (m0_gnt !== 1'b1 || mem_we !== 1'b0 || mem_we_sel !== 4'h0 || m0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_cmd: got gnt=%b we=%b sel=%h rv=%b, expected 1 0 0 0", m0_gnt, mem_we, mem_we_sel, m0_rvalid);
        end
        @(posedge sys_clk); #1 m0_req = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== exp_mem[16]) begin
            errors++; $display("FAIL rd_return: got rv=%b data=%h, expected 1 %h", m0_rvalid, m0_rdata, exp_mem[16]);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_we_sel !== 4'h0 || mem_addr !== 5'h10) begin
            errors++; $display("FAIL idle_hold: got we=%b sel=%h addr=%h, expected 0 0 10", mem_we, mem_we_sel, mem_addr);
        end
    endtask

    task automatic test_alternate;
        int gp;
        ev_vld = 1'b0;
        @(posedge sys_clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'h07;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                @(posedge sys_clk); #1 m0_req = 1'b0; m1_req = 1'b0;
            end
            @(negedge sys_clk);
            exp_rv = ev_vld ? (ev_port ? 2'b01 : 2'b10) : 2'b00;
            exp_d0 = (ev_vld && !ev_port) ? ev_data : 32'h0;
            exp_d1 = (ev_vld &&  ev_port) ? ev_data : 32'h0;
            checks++;
            if ({m0_rvalid, m1_rvalid} !== exp_rv || m0_rdata !== exp_d0 || m1_rdata !== exp_d1) begin
                errors++;
                $display("FAIL alt_rvalid%0d: got rv=%b d0=%h d1=%h, expected rv=%b d0=%h d1=%h",
                         i, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, exp_rv, exp_d0, exp_d1);
            end
            if (i < 6) begin
                gp = 1 - last_port;
                checks++;
                if ({m0_gnt, m1_gnt} !== ((gp == 1) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL alt_grant%0d: got %b%b, expected port %0d only", i, m0_gnt, m1_gnt, gp);
                end
                ev_vld = 1'b1; ev_port = (gp == 1);
                ev_data = exp_mem[(gp == 1) ? 7 : 16];
                last_port = gp;
            end
        end
        ev_vld = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int a = 1; a <= 3; a++) begin
            ram[a] = 32'hC0DE0000 + 32'(a);
            exp_mem[a] = 32'hC0DE0000 + 32'(a);
        end
        ev_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk); #1;
            m1_req = (i < 3); m1_we = 1'b0; m1_addr = ADDR_W'(i + 1);
            @(negedge sys_clk);
            exp_rv = ev_vld ? 2'b01 : 2'b00;
            exp_d1 = ev_vld ? ev_data : 32'h0;
            checks++;
            if ({m0_rvalid, m1_rvalid} !== exp_rv || m1_rdata !== exp_d1 || m0_rdata !== 32'h0) begin
                errors++;
                $display("FAIL b2b_rvalid%0d: got rv=%b d1=%h d0=%h, expected rv=%b d1=%h d0=0",
                         i, {m0_rvalid, m1_rvalid}, m1_rdata, m0_rdata, exp_rv, exp_d1);
            end
            if (i < 3) begin
                checks++;
                if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
                    errors++; $display("FAIL b2b_grant%0d: got %b%b, expected 01", i, m0_gnt, m1_gnt);
                end
                ev_vld = 1'b1; ev_data = exp_mem[i + 1]; last_port = 1;
            end else begin
                ev_vld = 1'b0;
            end
        end
    endtask

    task automatic test_random;
        logic              r_req [2];
        logic              r_we  [2];
        logic [3:0]        r_sel [2];
        logic [ADDR_W-1:0] r_addr[2];
        logic [31:0]       r_wd  [2];
        logic              has_hold;
        logic [ADDR_W-1:0] hold_addr;
        logic [1:0]        exp_g;
        int                gp;
        has_hold = 1'b0; hold_addr = '0; ev_vld = 1'b0;
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0; r_we[p] = 1'b0; r_sel[p] = 4'h0; r_addr[p] = '0; r_wd[p] = 32'h0;
        end
        for (int cyc = 0; cyc < 301; cyc++) begin
            @(posedge sys_clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (cyc == 300) r_req[p] = 1'b0;
                else if (!r_req[p] && $urandom_range(0, 9) < 6) begin
                    r_req[p] = 1'b1; r_we[p] = 1'($urandom); r_sel[p] = 4'($urandom);
                    r_addr[p] = ADDR_W'($urandom); r_wd[p] = $urandom;
                end
            end
            m0_req = r_req[0]; m0_we = r_we[0]; m0_sel = r_sel[0]; m0_addr = r_addr[0]; m0_wdata = r_wd[0];
            m1_req = r_req[1]; m1_we = r_we[1]; m1_sel = r_sel[1]; m1_addr = r_addr[1]; m1_wdata = r_wd[1];
            @(negedge sys_clk);
            if (r_req[0] && r_req[1]) gp = 1 - last_port;
            else if (r_req[0])        gp = 0;
            else if (r_req[1])        gp = 1;
            else                      gp = -1;
            exp_g = (gp == 0) ? 2'b10 : (gp == 1) ? 2'b01 : 2'b00;
            checks++;
            if ({m0_gnt, m1_gnt} !== exp_g) begin
                errors++; $display("FAIL rnd_grant@%0d: got %b%b, expected %b", cyc, m0_gnt, m1_gnt, exp_g);
            end
            exp_rv = ev_vld ? (ev_port ? 2'b01 : 2'b10) : 2'b00;
            exp_d0 = (ev_vld && !ev_port) ? ev_data : 32'h0;
            exp_d1 = (ev_vld &&  ev_port) ? ev_data : 32'h0;
            checks++;
            if ({m0_rvalid, m1_rvalid} !== exp_rv || m0_rdata !== exp_d0 || m1_rdata !== exp_d1) begin
                errors++;
                $display("FAIL rnd_rvalid@%0d: got rv=%b d0=%h d1=%h, expected rv=%b d0=%h d1=%h",
                         cyc, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, exp_rv, exp_d0, exp_d1);
            end
            checks++;
            if (gp >= 0) begin
                if (mem_addr !== r_addr[gp] || mem_we !== r_we[gp] ||
                    mem_we_sel !== (r_we[gp] ? r_sel[gp] : 4'h0) || (r_we[gp] && mem_data_wr !== r_wd[gp])) begin
                    errors++;
                    $display("FAIL rnd_cmd@%0d: got addr=%h we=%b sel=%h data=%h, expected addr=%h we=%b sel=%h data=%h",
                             cyc, mem_addr, mem_we, mem_we_sel, mem_data_wr, r_addr[gp], r_we[gp],
                             r_we[gp] ? r_sel[gp] : 4'h0, r_wd[gp]);
                end
                if (r_we[gp]) begin
                    exp_mem[r_addr[gp]] = merge(exp_mem[r_addr[gp]], r_wd[gp], r_sel[gp]);
                    ev_vld = 1'b0;
                end else begin
                    ev_vld = 1'b1; ev_port = (gp == 1); ev_data = exp_mem[r_addr[gp]];
                end
                last_port = gp; r_req[gp] = 1'b0; hold_addr = r_addr[gp]; has_hold = 1'b1;
            end else begin
                if (mem_we !== 1'b0 || mem_we_sel !== 4'h0 || (has_hold && mem_addr !== hold_addr)) begin
                    errors++;
                    $display("FAIL rnd_idle@%0d: got we=%b sel=%h addr=%h, expected 0 0 %h", cyc, mem_we, mem_we_sel, mem_addr, hold_addr);
                end
                ev_vld = 1'b0;
            end
        end
        ev_vld = 1'b0;
    endtask

`ifdef CACHE_ARB_LOCK_EN
    task automatic test_lock;
        if (last_port == 0) begin
            @(posedge sys_clk); #1 m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd1;
            @(negedge sys_clk);
            @(posedge sys_clk); #1 m1_req = 1'b0;
            last_port = 1;
        end
        @(posedge sys_clk); #1;
        m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 5'd2;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== 2'b10) begin
                errors++; $display("FAIL lock_hold%0d: got %b%b, expected 10", i, m0_gnt, m1_gnt);
            end
            @(posedge sys_clk); #1;
        end
        m0_lock = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_release: got %b%b, expected 01", m0_gnt, m1_gnt);
        end
        @(posedge sys_clk); #1 m0_req = 1'b0; m1_req = 1'b0;
        @(negedge sys_clk);
        last_port = 1;
    endtask
`endif

    task automatic test_reset_mid;
        @(posedge sys_clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'h10; m1_req = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_grant: got %b, expected 1", m0_gnt);
        end
        @(posedge sys_clk); #1 sys_rst = 1'b1; m0_req = 1'b0;
        #1;
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_drop: got rv=%b data=%h, expected 0 0", m0_rvalid, m0_rdata);
        end
        @(negedge sys_clk);
        checks++;
        if (init_busy !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_busy: got busy=%b we=%b, expected 1 0", init_busy, mem_we);
        end
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            checks++;
            if (m0_rvalid !== 1'b0 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL rstmid_sweep%0d: got rv=%b we=%b addr=%h, expected 0 1 %h", i, m0_rvalid, mem_we, mem_addr, ADDR_W'(i));
            end
        end
        #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge sys_clk);
            checks++;
            if (mem_addr !== ADDR_W'(i) || init_busy !== 1'b1 || mem_we !== 1'b1 || m0_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_restart%0d: got addr=%h busy=%b we=%b rv=%b, expected %h 1 1 0",
                         i, mem_addr, init_busy, mem_we, m0_rvalid, ADDR_W'(i));
            end
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            ram[a] = 32'hA5A5A5A5;
            exp_mem[a] = 32'hA5A5A5A5;
        end
        test_reset;
        test_clear;
        test_write_read;
        test_alternate;
        test_back_to_back;
        test_random;
`ifdef CACHE_ARB_LOCK_EN
        test_lock;
`endif
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
